// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply / divide unit with HI/LO result registers.
//   MULT: radix-2 Booth, one step per RUN cycle, {hi,lo} = 64-bit signed product.
//   DIV : restoring division on operand magnitudes, signs fixed up at FINISH;
//         lo = quotient (truncating toward zero), hi = remainder (sign of dividend).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start, op       request a new op in IDLE; op 0 = MULT, 1 = DIV
//   a, b            operands, latched on the accepting edge
//   busy            high in RUN and FINISH
//   done            one-cycle pulse, results valid from this cycle
//   div_zero        last accepted DIV had b = 0 (held until next accepted start)
//   hi, lo          result registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic             neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0] m_q;      // MULT: multiplicand; DIV: divisor magnitude
  logic [WIDTH:0]   acc_q;    // MULT: upper product half (+guard); DIV: partial remainder
  logic [WIDTH-1:0] qr_q;     // MULT: multiplier / lower half; DIV: dividend -> quotient
  logic             qm1_q;    // Booth q[-1]
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dz_q;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Booth step
  logic [WIDTH:0]   m_ext, booth_sum, booth_acc_d;
  logic [WIDTH-1:0] booth_qr_d;

  // Restoring-division step
  logic [WIDTH:0]   rem_sh, rem_diff, div_acc_d;
  logic [WIDTH-1:0] div_qr_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (op && (b == '0)) ? S_FINISH : S_RUN;
      S_RUN:    if (last_iter) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_RUN, S_FINISH: busy = 1'b1;
      default:         busy = 1'b0;
    endcase
  end

  assign accept    = (state_q == S_IDLE) && start;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // Booth: acc carries one guard bit so adding/subtracting the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  assign m_ext = {m_q[WIDTH-1], m_q};
  always_comb begin
    booth_sum = acc_q;
    case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
  end
  assign booth_acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_qr_d  = {booth_sum[0], qr_q[WIDTH-1:1]};

  // Restoring division: shift in the next dividend bit, trial-subtract, and
  // keep the difference only if it did not go negative.
  assign rem_sh   = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, m_q};
  always_comb begin
    if (rem_diff[WIDTH]) begin
      div_acc_d = rem_sh;
      div_qr_d  = {qr_q[WIDTH-2:0], 1'b0};
    end else begin
      div_acc_d = rem_diff;
      div_qr_d  = {qr_q[WIDTH-2:0], 1'b1};
    end
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      op_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= '0;
      acc_q     <= '0;
      qr_q      <= '0;
      qm1_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_FINISH);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            op_q      <= op;
            neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_q <= a[WIDTH-1];
            m_q       <= op ? b_mag : a;
            qr_q      <= op ? a_mag : b;
            acc_q     <= '0;
            qm1_q     <= 1'b0;
            dz_q      <= 1'b0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q) begin
            acc_q <= div_acc_d;
            qr_q  <= div_qr_d;
          end else begin
            acc_q <= booth_acc_d;
            qr_q  <= booth_qr_d;
            qm1_q <= qr_q[0];
          end
        end
        S_FINISH: begin
          // m_q holds |b| for DIV, which is zero exactly when b was zero.
          if (op_q && (m_q == '0)) begin
            dz_q <= 1'b1;
          end else if (op_q) begin
            lo_q <= neg_quo_q ? (~qr_q + 1'b1) : qr_q;
            hi_q <= neg_rem_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
          end else begin
            hi_q <= acc_q[WIDTH-1:0];
            lo_q <= qr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand-written corner sequences.
module tb_mult_div_unit;
  logic        clk, reset, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        dz;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Issue one op, scramble operands after the accepting edge, and report the
  // edge count at which done was seen plus the number of busy cycles.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    lat = -1; bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; op = ~o;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, bcnt, seen;
    start = 1'b0; op = 1'b0; a = '0; b = '0; reset = 1'b0;

    vt[0]  = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33};
    vt[1]  = '{1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 33};
    vt[2]  = '{1'b0, 32'h12345678,   32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34, 33};
    vt[3]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34, 33};
    vt[4]  = '{1'b0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34, 33};
    vt[5]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33};
    vt[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 33};
    vt[7]  = '{1'b1, 32'd100,        32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34, 33};
    vt[8]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 33};
    vt[9]  = '{1'b1, 32'd3,          32'd5,        32'h00000003, 32'h00000000, 1'b0, 34, 33};
    vt[10] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFE, 32'h00000000, 32'h00000004, 1'b0, 34, 33};
    vt[11] = '{1'b1, 32'd5,          32'd2,        32'h00000001, 32'h00000002, 1'b0, 34, 33};
    vt[12] = '{1'b1, 32'd5,          32'd0,        32'h00000001, 32'h00000002, 1'b1, 2,  1};
    vt[13] = '{1'b0, 32'd3,          32'd4,        32'h00000000, 32'h0000000C, 1'b0, 34, 33};

    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(div_zero), 64'd0);
    chk("rst_hi",   64'(hi), 64'd0);
    chk("rst_lo",   64'(lo), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, lat, bcnt);
      chk($sformatf("v%0d_lat", i),  64'(lat),  64'(vt[i].lat));
      chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'(vt[i].bsy));
      chk($sformatf("v%0d_hi", i),   64'(hi),   64'(vt[i].hi));
      chk($sformatf("v%0d_lo", i),   64'(lo),   64'(vt[i].lo));
      chk($sformatf("v%0d_dz", i),   64'(div_zero), 64'(vt[i].dz));
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), 64'(done), 64'd0);
      if (vt[i].dz) begin
        repeat (3) @(posedge clk);
        #1 chk($sformatf("v%0d_dzhold", i), 64'(div_zero), 64'd1);
      end
    end

    // MULT 3x4, ignored start at edge 10, reset asserted just after edge 20.
    @(negedge clk);
    op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
    seen = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1)  start = 1'b0;
      if (n == 9)  begin op = 1'b1; b = 32'd0; start = 1'b1; end
      if (n == 10) start = 1'b0;
      if (n == 15) chk("c2_busy_mid", 64'(busy), 64'd1);
      if (done) seen++;
    end
    #2 reset = 1'b1;
    #1;
    chk("c2_async_lo",   64'(lo), 64'd0);
    chk("c2_async_hi",   64'(hi), 64'd0);
    chk("c2_async_busy", 64'(busy), 64'd0);
    chk("c2_async_done", 64'(done), 64'd0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("c2_rst_start_ign", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("c2_no_done", 64'(seen), 64'd0);
    run_op(1'b0, 32'd3, 32'd4, lat, bcnt);
    chk("c2_post_lo",  64'(lo), 64'd12);
    chk("c2_post_hi",  64'(hi), 64'd0);
    chk("c2_post_lat", 64'(lat), 64'd34);

    // Back-to-back: DIV overflow case then MULT 2x2, start held through done.
    @(negedge clk);
    op = 1'b1; a = 32'h80000000; b = 32'hFFFFFFFF; start = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    chk("c3_div_lat", 64'(lat), 64'd34);
    chk("c3_div_lo",  64'(lo), 64'h80000000);
    chk("c3_div_hi",  64'(hi), 64'd0);
    chk("c3_div_dz",  64'(div_zero), 64'd0);
    op = 1'b0; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("c3_restart_busy", 64'(busy), 64'd1);
    lat = -1;
    for (int n = 2; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    chk("c3_mul_lat", 64'(lat), 64'd34);
    chk("c3_mul_lo",  64'(lo), 64'd4);
    chk("c3_mul_hi",  64'(hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; the datapath uses 32, and all values below assume 32.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous reset, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  0 = signed multiply (MULT), 1 = signed divide (DIV).
REQ-006 a  input  WIDTH  operand A (register A output); multiplicand or dividend.
REQ-007 b  input  WIDTH  operand B (register B output, same source as ALUSrcB select 00); multiplier or divisor.
REQ-008 busy  output  1  high while an operation is in progress (states RUN and FINISH).
REQ-009 done  output  1  one-cycle pulse; hi/lo/div_zero are valid from this cycle.
REQ-010 div_zero  output  1  high when the last accepted DIV had b = 0.
REQ-011 hi  output  WIDTH  HI register: product upper half, or remainder.
REQ-012 lo  output  WIDTH  LO register: product lower half, or quotient.

Function
REQ-013 State machine has three states: IDLE, RUN, FINISH; the 5-bit iteration counter is valid in RUN only.
REQ-014 In IDLE with start = 1, the edge latches a, b and op, and clears div_zero and the counter.
REQ-015 On that same edge, the next state is RUN, except for op = 1 with b = 0, where the next state is FINISH.
REQ-016 Each RUN edge performs one iteration; the 32nd RUN edge moves to FINISH.
REQ-017 The FINISH edge loads hi/lo (or sets div_zero), asserts done for exactly one cycle, and returns to IDLE.
REQ-018 Latency, normal case: done is high in the cycle after the 34th rising edge, counted from the edge that sampled start.
REQ-019 Latency, divide by zero: done is high in the cycle after the 2nd edge.
REQ-020 busy is high from the cycle after the start edge until the FINISH edge; it is low in the done cycle.
REQ-021 start while busy is ignored; start during the done cycle is accepted, because the state is IDLE.
REQ-022 MULT: {hi,lo} = the full 64-bit two's-complement product of a and b; radix-2 Booth, one step per RUN cycle.
REQ-023 DIV (signed, truncating toward zero): lo = quotient; hi = remainder, carrying the sign of the dividend.
REQ-024 DIV datapath: restoring division on magnitudes, with sign correction applied at FINISH.
REQ-025 DIV by zero: hi and lo keep their previous values, div_zero = 1, and done pulses.
REQ-026 div_zero holds until the next accepted start.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000 and hi = 0; no exception flag is raised.
REQ-028 hi and lo change only on a FINISH edge of a non-zero-divisor operation; they hold otherwise.
REQ-029 Changes on a, b or op after the start edge have no effect on the operation in progress.

Reset
REQ-030 Assertion of reset immediately, without waiting for clk, forces: state IDLE, counter 0, busy 0, done 0, div_zero 0, hi 0x00000000, lo 0x00000000.
REQ-031 Reset during RUN or FINISH aborts the operation: no done pulse and no hi/lo update.
REQ-032 The first edge after reset release may accept start.
REQ-033 With reset held high, start is ignored.

Verification
REQ-034 MULT a = 7, b = -3 (0xFFFFFFFD) -> done after 34 edges; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for 33 cycles.
REQ-035 MULT a = 0x80000000, b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-036 DIV a = -7, b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), div_zero = 0.
REQ-037 Case 1: run DIV a = 5, b = 0 after a prior result hi = 1, lo = 2.
        Required response: done after 2 edges; div_zero = 1; hi = 1, lo = 2 unchanged.
REQ-038 Case 2: during MULT 3 x 4, pulse start with op = 1 at edge 10, then assert reset at edge 20.
        Required response: second start ignored; outputs return to reset values asynchronously; no done pulse.
        Post-reset check: a new MULT 3 x 4 then gives lo = 12, hi = 0.
REQ-039 Case 3: DIV 0x80000000 / 0xFFFFFFFF followed back-to-back by MULT 2 x 2, with start held through the done cycle.
        Required response: lo = 0x80000000, hi = 0; the second operation starts on the done cycle; final lo = 4.
